// File: rtl/interlaken_pkg.sv
// Shared constants and types for the Interlaken 64B/67B TX encoder.
package interlaken_pkg;

  localparam int PAYLOAD_W = 64;
  localparam int HDR_W     = 2;
  localparam int ENC_W     = 67;
  localparam int SLOT_W    = 80;
  localparam int SLOT_PAD  = 13;
  localparam int PT_PAD    = 16;
  localparam int POP_W     = 7;
  localparam int DISP_W    = 10;

  // Signed disparity of a single 67-bit candidate word (range -67..+67).
  typedef logic signed [DISP_W-1:0] disp_t;

  localparam logic [HDR_W-1:0] DATA_HDR = 2'b01;
  localparam logic [HDR_W-1:0] CTRL_HDR = 2'b10;

  // Number of ones in a 64-bit payload (0..64).
  function automatic logic [POP_W-1:0] popcount64(input logic [PAYLOAD_W-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < PAYLOAD_W; i++) c = c + POP_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/encode_64b67b_lane_core.sv
// Combinational 64B/67B encode decision for one lane: picks the plain or
// inverted candidate that keeps the running disparity closest to zero,
// or passes the payload straight through with RD cleared.
module encode_64b67b_lane_core
  import interlaken_pkg::*;
#(
  parameter int RD_W = 9
) (
  input  logic [POP_W-1:0]        popcnt_i,
  input  logic [HDR_W-1:0]        hdr_i,
  input  logic [PAYLOAD_W-1:0]    data_i,
  input  logic signed [RD_W-1:0]  rd_i,
  input  logic                    pass_i,
  output logic [SLOT_W-1:0]       slot_o,
  output logic signed [RD_W-1:0]  rd_next_o
);

  // Arithmetic width wide enough for RD plus one word's disparity.
  localparam int CW = (RD_W + 1 > DISP_W) ? RD_W + 1 : DISP_W;
  typedef logic signed [CW-1:0] acc_t;

  localparam acc_t ENC_BITS = acc_t'(ENC_W);
  localparam acc_t W1_FIXED = acc_t'(1 + PAYLOAD_W);

  acc_t pop_s, hdr_s, rd_s;
  acc_t d0, d1, sum0, sum1, abs0, abs1;
  logic inv;

  // Disparity of both candidates and the resulting |RD| for each.
  always_comb begin
    pop_s = acc_t'(popcnt_i);
    hdr_s = acc_t'({1'b0, hdr_i[1]} + {1'b0, hdr_i[0]});
    rd_s  = acc_t'(rd_i);
    // W0 = {0,H,D}: ones = ph + p.  W1 = {1,H,~D}: ones = 1 + ph + 64 - p.
    d0    = ((hdr_s + pop_s) <<< 1) - ENC_BITS;
    d1    = ((W1_FIXED + hdr_s - pop_s) <<< 1) - ENC_BITS;
    sum0  = rd_s + d0;
    sum1  = rd_s + d1;
    abs0  = sum0[CW-1] ? -sum0 : sum0;
    abs1  = sum1[CW-1] ? -sum1 : sum1;
    // Strictly smaller magnitude wins; a tie keeps the uninverted word.
    inv   = (abs1 < abs0);
  end

  // Slot formatting and next running disparity.
  always_comb begin
    slot_o    = '0;
    rd_next_o = '0;
    if (pass_i) begin
      slot_o    = {{PT_PAD{1'b0}}, data_i};
      rd_next_o = '0;
    end else begin
      slot_o    = {{SLOT_PAD{1'b0}}, inv, hdr_i, (inv ? ~data_i : data_i)};
      rd_next_o = inv ? RD_W'(sum1) : RD_W'(sum0);
    end
  end

endmodule

// File: rtl/encode_64b67b_lanes.sv
// Multi-lane 64B/67B encoder with a 2-stage valid/ready pipeline.
// S1 registers the input group plus per-lane popcount; S2 applies the
// encode decision and holds the output slot and per-lane running disparity.
// Optional feature macro: ENCODE_DISP_MONITOR_EN adds a sticky DISP_ERR flag
// per lane when |RD| exceeds RD_LIMIT after an update.
//
// Handshake: a word transfers on a clock edge where VALID && READY. A source
// holds VALID and its data stable until it transfers; READY may depend
// combinationally on the downstream READY. OUT_VALID && !OUT_READY keeps
// DATA_OUT and RD_OUT unchanged.
module encode_64b67b_lanes
  import interlaken_pkg::*;
#(
  parameter int LANES    = 1,
  parameter int RD_W     = 9,
  parameter int RD_LIMIT = 72
) (
  input  logic                        USER_CLK,
  input  logic                        SYSTEM_RESET,
  input  logic                        PASSTHROUGH,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  input  logic [LANES*PAYLOAD_W-1:0]  DATA_IN,
  input  logic [LANES*HDR_W-1:0]      HEADER_IN,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [LANES*SLOT_W-1:0]     DATA_OUT,
  output logic [LANES*RD_W-1:0]       RD_OUT
`ifdef ENCODE_DISP_MONITOR_EN
  ,
  output logic [LANES-1:0]            DISP_ERR
`endif
);

  if (RD_W < 8 || RD_LIMIT < 0) begin : g_param_check
    $error("encode_64b67b_lanes: RD_W must be >= 8 and RD_LIMIT >= 0");
  end

  logic                        s1_valid_q, s1_valid_d;
  logic [LANES*PAYLOAD_W-1:0]  s1_data_q, s1_data_d;
  logic [LANES*HDR_W-1:0]      s1_hdr_q, s1_hdr_d;
  logic                        s1_pass_q, s1_pass_d;
  logic [LANES*POP_W-1:0]      s1_pop_q, s1_pop_d;

  logic                        out_valid_q, out_valid_d;
  logic [LANES*SLOT_W-1:0]     data_out_q, data_out_d;
  logic [LANES*RD_W-1:0]       rd_q, rd_d;

  logic                        s2_load, s1_load, in_ready;
  logic [LANES*POP_W-1:0]      pop_in;
  logic [LANES*SLOT_W-1:0]     slot_w;
  logic [LANES*RD_W-1:0]       rd_next_w;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign pop_in[l*POP_W +: POP_W] = popcount64(DATA_IN[l*PAYLOAD_W +: PAYLOAD_W]);

    encode_64b67b_lane_core #(
      .RD_W (RD_W)
    ) u_core (
      .popcnt_i  (s1_pop_q[l*POP_W +: POP_W]),
      .hdr_i     (s1_hdr_q[l*HDR_W +: HDR_W]),
      .data_i    (s1_data_q[l*PAYLOAD_W +: PAYLOAD_W]),
      .rd_i      (rd_q[l*RD_W +: RD_W]),
      .pass_i    (s1_pass_q),
      .slot_o    (slot_w[l*SLOT_W +: SLOT_W]),
      .rd_next_o (rd_next_w[l*RD_W +: RD_W])
    );
  end

  // Stage advance conditions: S2 moves when its slot is free or draining.
  always_comb begin
    s2_load  = s1_valid_q && (!out_valid_q || OUT_READY);
    in_ready = !s1_valid_q || s2_load;
    s1_load  = IN_VALID && in_ready;
  end

  // S1 next state: capture the input group and its popcounts.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_hdr_d   = s1_hdr_q;
    s1_pass_d  = s1_pass_q;
    s1_pop_d   = s1_pop_q;
    if (in_ready) s1_valid_d = IN_VALID;
    if (s1_load) begin
      s1_data_d = DATA_IN;
      s1_hdr_d  = HEADER_IN;
      s1_pass_d = PASSTHROUGH;
      s1_pop_d  = pop_in;
    end
  end

  // S2 next state: output slot and RD change only on an S2 load.
  always_comb begin
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    rd_d        = rd_q;
    if (!out_valid_q || OUT_READY) out_valid_d = s1_valid_q;
    if (s2_load) begin
      data_out_d = slot_w;
      rd_d       = rd_next_w;
    end
  end

  // Pipeline registers.
  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_hdr_q    <= '0;
      s1_pass_q   <= 1'b0;
      s1_pop_q    <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      rd_q        <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_hdr_q    <= s1_hdr_d;
      s1_pass_q   <= s1_pass_d;
      s1_pop_q    <= s1_pop_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      rd_q        <= rd_d;
    end
  end

`ifdef ENCODE_DISP_MONITOR_EN
  logic [LANES-1:0] disp_err_q, disp_err_d;

  // Sticky per-lane flag when the updated |RD| exceeds the limit.
  always_comb begin
    int mag;
    disp_err_d = disp_err_q;
    mag        = 0;
    if (s2_load) begin
      for (int l = 0; l < LANES; l++) begin
        mag = int'($signed(rd_next_w[l*RD_W +: RD_W]));
        if (mag < 0) mag = -mag;
        if (s1_pass_q) disp_err_d[l] = 1'b0;
        else if (mag > RD_LIMIT) disp_err_d[l] = 1'b1;
      end
    end
  end

  // Monitor flag register.
  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) disp_err_q <= '0;
    else              disp_err_q <= disp_err_d;
  end

  assign DISP_ERR = disp_err_q;
`endif

  assign IN_READY  = in_ready;
  assign OUT_VALID = out_valid_q;
  assign DATA_OUT  = data_out_q;
  assign RD_OUT    = rd_q;

endmodule

// File: tb/tb_encode_64b67b_lanes.sv
// Directed bench for encode_64b67b_lanes with 4 lanes and RD_W=9.
module tb_encode_64b67b_lanes;

  localparam int LANES = 4;
  localparam int RD_W  = 9;
  localparam int EW    = LANES*80 + LANES*RD_W;

  logic                 USER_CLK;
  logic                 SYSTEM_RESET;
  logic                 PASSTHROUGH;
  logic                 IN_VALID;
  logic                 IN_READY;
  logic [LANES*64-1:0]  DATA_IN;
  logic [LANES*2-1:0]   HEADER_IN;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic [LANES*80-1:0]  DATA_OUT;
  logic [LANES*RD_W-1:0] RD_OUT;
`ifdef ENCODE_DISP_MONITOR_EN
  logic [LANES-1:0]     disp_err;
`endif

  encode_64b67b_lanes #(
    .LANES    (LANES),
    .RD_W     (RD_W),
    .RD_LIMIT (72)
  ) dut (
    .USER_CLK     (USER_CLK),
    .SYSTEM_RESET (SYSTEM_RESET),
    .PASSTHROUGH  (PASSTHROUGH),
    .IN_VALID     (IN_VALID),
    .IN_READY     (IN_READY),
    .DATA_IN      (DATA_IN),
    .HEADER_IN    (HEADER_IN),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .DATA_OUT     (DATA_OUT),
    .RD_OUT       (RD_OUT)
`ifdef ENCODE_DISP_MONITOR_EN
    ,
    .DISP_ERR     (disp_err)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    USER_CLK = 1'b0;
    forever #5 USER_CLK = ~USER_CLK;
  end

  int cyc = 0;
  always @(posedge USER_CLK) cyc <= cyc + 1;

  // 0: always ready, 1: random stalls, 2: held off
  int rdy_mode = 0;
  always @(negedge USER_CLK) begin
    case (rdy_mode)
      1:       OUT_READY = ($urandom_range(0, 3) != 0);
      2:       OUT_READY = 1'b0;
      default: OUT_READY = 1'b1;
    endcase
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  int m_rd[LANES];

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: builds both 67-bit candidates and counts their ones.
  task automatic model_word(input logic [LANES*64-1:0] d, input logic [LANES*2-1:0] h,
                            input logic pt, output logic [EW-1:0] e);
    logic [66:0] w0, w1;
    int c0, c1, s0, s1, a0, a1;
    e = '0;
    for (int l = 0; l < LANES; l++) begin
      if (pt) begin
        e[80*l +: 80] = {16'b0, d[64*l +: 64]};
        m_rd[l] = 0;
      end else begin
        w0 = {1'b0, h[2*l +: 2], d[64*l +: 64]};
        w1 = {1'b1, h[2*l +: 2], ~d[64*l +: 64]};
        c0 = $countones(w0);
        c1 = $countones(w1);
        s0 = m_rd[l] + 2*c0 - 67;
        s1 = m_rd[l] + 2*c1 - 67;
        a0 = (s0 < 0) ? -s0 : s0;
        a1 = (s1 < 0) ? -s1 : s1;
        if (a1 < a0) begin
          e[80*l +: 80] = {13'b0, w1};
          m_rd[l] = s1;
        end else begin
          e[80*l +: 80] = {13'b0, w0};
          m_rd[l] = s0;
        end
      end
      e[LANES*80 + RD_W*l +: RD_W] = RD_W'(m_rd[l]);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int l = 0; l < LANES; l++) m_rd[l] = 0;
  endtask

  // Output monitor: every valid cycle must match the queue head.
  initial begin
    logic ok;
    int r;
    forever begin
      @(negedge USER_CLK);
      #2;
      if (!SYSTEM_RESET && OUT_VALID) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {{(EW-1){1'b0}}, OUT_VALID}, '0);
        end else begin
          check("out", {RD_OUT, DATA_OUT}, exp_q[0]);
          if (OUT_READY) begin
            ok = 1'b1;
            for (int l = 0; l < LANES; l++) begin
              r = int'($signed(RD_OUT[RD_W*l +: RD_W]));
              if (r > 71 || r < -71) ok = 1'b0;
            end
            check("rd_bound", {{(EW-1){1'b0}}, ok}, 1);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [LANES*64-1:0] d, input logic [LANES*2-1:0] h,
                      input logic pt, output int acc);
    logic [EW-1:0] e;
    logic done;
    done = 1'b0;
    acc  = -1;
    @(negedge USER_CLK);
    DATA_IN     = d;
    HEADER_IN   = h;
    PASSTHROUGH = pt;
    IN_VALID    = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      #1;
      if (IN_READY) begin
        acc = cyc;
        @(posedge USER_CLK);
        model_word(d, h, pt, e);
        exp_q.push_back(e);
        done = 1'b1;
      end else begin
        @(negedge USER_CLK);
      end
    end
    #1 IN_VALID = 1'b0;
    check("send_accepted", {{(EW-1){1'b0}}, done}, 1);
  endtask

  task automatic expect_out(input string tag, input logic [EW-1:0] exp, output int seen);
    logic got;
    got  = 1'b0;
    seen = -1;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge USER_CLK);
      #2;
      if (OUT_VALID && OUT_READY) begin
        check(tag, {RD_OUT, DATA_OUT}, exp);
        seen = cyc;
        got  = 1'b1;
      end
    end
    check({tag, "_seen"}, {{(EW-1){1'b0}}, got}, 1);
  endtask

  task automatic mid_clock_reset(input string tag);
    @(negedge USER_CLK);
    #3 SYSTEM_RESET = 1'b1;
    #1;
    check({tag, "_data"},  DATA_OUT, '0);
    check({tag, "_valid"}, {{(EW-1){1'b0}}, OUT_VALID}, '0);
    check({tag, "_rd"},    RD_OUT, '0);
    model_reset();
    @(negedge USER_CLK);
    #3 SYSTEM_RESET = 1'b0;
  endtask

  function automatic logic [LANES*64-1:0] rand_data();
    logic [LANES*64-1:0] v;
    for (int i = 0; i < LANES*2; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [LANES*2-1:0] rand_hdr();
    logic [LANES*2-1:0] v;
    for (int l = 0; l < LANES; l++) v[2*l +: 2] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIX  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ALT  = 64'hAAAA_AAAA_AAAA_AAAA;

  initial begin
    logic [LANES*64-1:0] d_all1, d_pt, d_mixed;
    logic [LANES*2-1:0]  h_data, h_mixed;
    logic [EW-1:0]       exp_a, exp_b, exp_d, exp1, exp2;
    int a1, a2, f1, f2, dummy;

    SYSTEM_RESET = 1'b1;
    PASSTHROUGH  = 1'b0;
    IN_VALID     = 1'b0;
    DATA_IN      = '0;
    HEADER_IN    = '0;
    model_reset();

    // Reset state
    #23;
    check("rst_data",  DATA_OUT, '0);
    check("rst_valid", {{(EW-1){1'b0}}, OUT_VALID}, '0);
    check("rst_rd",    RD_OUT, '0);
    SYSTEM_RESET = 1'b0;
    @(negedge USER_CLK);
    #1;
    check("rst_in_ready", {{(EW-1){1'b0}}, IN_READY}, 1);

    // Two back-to-back words, lanes: ones/zeros/alternating/mixed
    d_mixed = {MIX, ALT, 64'h0, ONES};
    h_mixed = {2'b10, 2'b10, 2'b01, 2'b01};
    exp1 = {9'h1FF, 9'h1FF, 9'h1BF, 9'd63,
            13'b0, 1'b0, 2'b10, MIX,
            13'b0, 1'b0, 2'b10, ALT,
            13'b0, 1'b0, 2'b01, 64'h0,
            13'b0, 1'b0, 2'b01, ONES};
    exp2 = {36'h0,
            13'b0, 1'b1, 2'b10, 64'hFEDC_BA98_7654_3210,
            13'b0, 1'b1, 2'b10, 64'h5555_5555_5555_5555,
            13'b0, 1'b1, 2'b01, ONES,
            13'b0, 1'b1, 2'b01, 64'h0};
    fork
      begin
        send(d_mixed, h_mixed, 1'b0, a1);
        send(d_mixed, h_mixed, 1'b0, a2);
      end
      begin
        expect_out("lanes_w1", exp1, f1);
        expect_out("lanes_w2", exp2, f2);
      end
    join
    check("latency_w1", EW'(f1 - a1), 2);
    check("latency_w2", EW'(f2 - a2), 2);

    // Passthrough, toggle back, mid-clock reset, post-reset encode
    d_all1 = {LANES{ONES}};
    d_pt   = {LANES{MIX}};
    h_data = {LANES{2'b01}};
    exp_a  = {{LANES{9'd63}}, {LANES{13'b0, 1'b0, 2'b01, ONES}}};
    exp_b  = {36'h0, {LANES{16'b0, MIX}}};
    exp_d  = {36'h0, {LANES{13'b0, 1'b1, 2'b01, 64'h0}}};
    fork
      begin
        send(d_all1, h_data, 1'b0, dummy);
        send(d_pt,   h_data, 1'b1, dummy);
        send(d_all1, h_data, 1'b0, dummy);
      end
      begin
        expect_out("pre_pt", exp_a, f1);
        expect_out("pt_word", exp_b, f1);
        expect_out("post_pt", exp_a, f1);
      end
    join
    mid_clock_reset("midrst");
    fork
      begin
        send(d_all1, h_data, 1'b0, dummy);
        send(d_all1, h_data, 1'b0, dummy);
      end
      begin
        expect_out("post_rst_w1", exp_a, f1);
        expect_out("post_rst_w2", exp_d, f1);
      end
    join

    // Backpressure: two words fill the pipe, then IN_READY drops
    rdy_mode = 2;
    send(rand_data(), rand_hdr(), 1'b0, dummy);
    send(rand_data(), rand_hdr(), 1'b0, dummy);
    @(negedge USER_CLK);
    DATA_IN   = rand_data();
    HEADER_IN = rand_hdr();
    IN_VALID  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_in_ready", {{(EW-1){1'b0}}, IN_READY}, '0);
      @(negedge USER_CLK);
    end
    IN_VALID = 1'b0;
    rdy_mode = 0;
    for (int k = 0; k < 4; k++) send(rand_data(), rand_hdr(), 1'b0, dummy);

    // Random stream with random stalls and a reset mid-stream
    rdy_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) mid_clock_reset("stream_rst");
      send(rand_data(), rand_hdr(), ($urandom_range(0, 7) == 0), dummy);
      if ($urandom_range(0, 3) == 0) @(negedge USER_CLK);
    end

    // Drain
    rdy_mode = 0;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge USER_CLK);
    @(negedge USER_CLK);
    check("drain", EW'(exp_q.size()), 0);
`ifdef ENCODE_DISP_MONITOR_EN
    check("disp_err", EW'(disp_err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encode_64b67b_lanes.md
Name: encode_64b67b_lanes

Overview:
Parametrised multi-lane 64B/67B encoder for the Interlaken TX path. Sits between the framing layer and the gearbox/transceiver. Per lane: selects inversion from running disparity to minimise DC imbalance and emits a 67-bit word in an 80-bit lane slot. Adds a 2-stage valid/ready pipeline with backpressure and per-lane running-disparity (RD) visibility.

Parameters:
LANES, 1, number of independent 64-bit lanes
RD_W, 9, signed running-disparity register width per lane; must be >= 8
RD_LIMIT, 72, magnitude threshold for the optional disparity monitor

Ports:
USER_CLK  in  1  single clock
SYSTEM_RESET  in  1  asynchronous, active-high reset
PASSTHROUGH  in  1  bypass encoding; sampled with each accepted word
IN_VALID  in  1  input word group valid
IN_READY  out  1  block can accept this cycle
DATA_IN  in  LANES*64  lane n payload at [64n+63:64n]
HEADER_IN  in  LANES*2  lane n sync header at [2n+1:2n]
OUT_VALID  out  1  DATA_OUT valid
OUT_READY  in  1  downstream accepts
DATA_OUT  out  LANES*80  lane n slot at [80n+79:80n]
RD_OUT  out  LANES*RD_W  current per-lane RD, two's complement

Behaviour:
- Reset (async assert, sync release): DATA_OUT=0, OUT_VALID=0, both stage-valids=0, every lane RD=0, IN_READY=1 once reset deasserts.
- Pipeline: S1 registers DATA_IN, HEADER_IN, PASSTHROUGH, and per-lane popcount of DATA_IN (7 bits). S2 makes the encode decision and registers DATA_OUT.
- Latency: 2 cycles from an accepted input (IN_VALID&IN_READY) to OUT_VALID, with no stall.
- Advance rules: S2 loads when (!OUT_VALID || OUT_READY) && S1 valid. S1 loads when !S1valid || S2 loads. IN_READY = !S1valid || S2 loads. This gives full throughput, one group per cycle.
- Holding: OUT_VALID && !OUT_READY holds DATA_OUT stable. No word is lost or duplicated.
- Encode, per lane, at S2 load with PASSTHROUGH=0:
  - Candidates: W0={1'b0,H,D} and W1={1'b1,H,~D}.
  - Disparity: d(W) = 2*popcount(W) - 67.
  - Select W1 iff |RD+d(W1)| < |RD+d(W0)|. A tie selects W0.
  - Slot = {13'b0, selected W}.
  - RD <= RD + d(selected).
  - The rule bounds |RD| <= 71, so RD cannot overflow at RD_W >= 8.
- Passthrough (word's sampled PASSTHROUGH=1): slot = {16'b0, D}, header is dropped, lane RD is forced to 0.
- RD updates only on an S2 load. It is unchanged during stalls and while the pipeline is empty.
- Lanes are fully independent; there is no cross-lane disparity.
- Reset mid-stream discards in-flight words and clears RD. The first post-reset word encodes against RD=0.
- Changing PASSTHROUGH mid-stream affects only words accepted after the change.

Optional Feature:
Macro ENCODE_DISP_MONITOR_EN.
- Defined: adds output DISP_ERR [LANES]. Bit n sets (sticky) when lane n's post-update |RD| > RD_LIMIT. It clears on SYSTEM_RESET or on a passthrough word in that lane. This is a sanity/fault check; it never fires for correct logic at the default limit.
- Undefined: port and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package interlaken_pkg holds:
  - constants PAYLOAD_W=64, HDR_W=2, ENC_W=67, SLOT_W=80, SLOT_PAD=13, PT_PAD=16;
  - the signed-disparity width typedef;
  - the header encodings DATA_HDR=2'b01 and CTRL_HDR=2'b10.
- One natural sub-module, encode_64b67b_lane_core. It is purely combinational per lane: it takes popcount, H, D, RD and PASSTHROUGH, and returns slot and next RD. It is instantiated LANES times inside the pipeline/handshake top.

Test Plan:
- Reset: assert SYSTEM_RESET mid-clock -> DATA_OUT=0, OUT_VALID=0, RD_OUT=0 immediately. After release IN_READY=1.
- LANES=1, D=64'hFFFF_FFFF_FFFF_FFFF, H=2'b01, two consecutive words:
  - word 1: d0=+63, d1=-63, tie -> slot {13'b0,0,01,all-ones}, RD=63;
  - word 2: inverted -> slot {13'b0,1,01,64'h0}, RD=0;
  - each appears 2 cycles after acceptance.
- Backpressure: stream 6 words with OUT_READY=0 for 5 cycles -> IN_READY drops after 2 words accepted. All 6 words emerge in order, unchanged. RD_OUT is constant during the stall.
- Passthrough: PASSTHROUGH=1, D=64'h0123_4567_89AB_CDEF -> slot {16'b0,64'h0123_4567_89AB_CDEF} and that lane's RD=0. Toggle back -> the next word encodes against RD=0.
- LANES=4, per-lane patterns all-ones/all-zeros/alternating 64'hAAAA.../random -> each lane's slot and RD match a reference model; there is no cross-lane coupling.
- 10k random words with random stalls and a reset mid-stream -> output sequence matches the model, |RD|<=71 throughout. With ENCODE_DISP_MONITOR_EN at RD_LIMIT=10 -> DISP_ERR sets; reset clears it.
